// File: rtl/pin_mon_sub.sv
`default_nettype none
// ============================================================================
// Module   : pin_mon_sub
// Purpose  : Gated pin monitor. Counts reference-pin rising edges and flags
//            toggling pins over back-to-back gate windows. Optional 3-sample
//            majority glitch filter enabled by PIN_MON_GLITCH_FILT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pin_mon_sub #(
   parameter int PIN_W = 20,
   parameter int CNT_W = 32
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             sw_en,
   input  logic             set_gate_en,
   input  logic [CNT_W-1:0] set_gate,
   input  logic [4:0]       set_sel,
   input  logic [PIN_W-1:0] pins_in,
   output logic [CNT_W-1:0] meas_cnt,
   output logic [PIN_W-1:0] meas_pins,
   output logic             meas_valid,
   output logic             busy
);

   localparam logic [CNT_W-1:0] c_gate_rst = CNT_W'(1000);
   localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
   localparam logic [CNT_W-1:0] c_cnt_max  = '1;
   localparam logic [PIN_W-1:0] c_pin_one  = PIN_W'(1);
`ifdef PIN_MON_GLITCH_FILT_EN
   localparam logic [2:0]       c_fill     = 3'd6;
`else
   localparam logic [2:0]       c_fill     = 3'd3;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_GATE = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [PIN_W-1:0] r_sync1;
   logic [PIN_W-1:0] r_sync2;
   logic [PIN_W-1:0] r_prev;
   logic [2:0]       r_arm;
   logic [CNT_W-1:0] r_gate;
   logic [4:0]       r_sel;
   logic [CNT_W-1:0] r_gcnt;
   logic [CNT_W-1:0] r_ecnt;
   logic [PIN_W-1:0] r_tmask;
   logic [CNT_W-1:0] r_meas_cnt;
   logic [PIN_W-1:0] r_meas_pins;
   logic             r_meas_valid;
   logic             r_busy;

   logic [PIN_W-1:0] w_det;
   logic             w_armed;
   logic [PIN_W-1:0] w_rise;
   logic [PIN_W-1:0] w_tog;
   logic             w_sel_rise;
   logic [CNT_W-1:0] w_ecnt_nxt;
   logic [PIN_W-1:0] w_tmask_nxt;
   logic             w_last;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= pins_in;
         r_sync2 <= r_sync1;
      end
   end

`ifdef PIN_MON_GLITCH_FILT_EN
   logic [PIN_W-1:0] r_hist1;
   logic [PIN_W-1:0] r_hist2;
   logic [PIN_W-1:0] r_filt;
   logic [PIN_W-1:0] w_maj;

   assign w_maj = (r_sync2 & r_hist1) | (r_sync2 & r_hist2) | (r_hist1 & r_hist2);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_hist1 <= '0;
         r_hist2 <= '0;
         r_filt  <= '0;
      end else begin
         r_hist1 <= r_sync2;
         r_hist2 <= r_hist1;
         r_filt  <= w_maj;
      end
   end

   assign w_det = r_filt;
`else
   assign w_det = r_sync2;
`endif

   // Detection stays blind until the whole pipeline holds real pin samples,
   // so the post-reset fill never registers as an edge.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_prev <= '0;
         r_arm  <= 3'd0;
      end else begin
         r_prev <= w_det;
         if (r_arm != c_fill) begin
            r_arm <= r_arm + 3'd1;
         end
      end
   end

   assign w_armed     = (r_arm == c_fill);
   assign w_rise      = w_armed ? (w_det & ~r_prev) : '0;
   assign w_tog       = w_armed ? (w_det ^ r_prev) : '0;
   assign w_sel_rise  = |(w_rise & (c_pin_one << r_sel));
   assign w_ecnt_nxt  = (w_sel_rise && (r_ecnt != c_cnt_max)) ? r_ecnt + c_cnt_one : r_ecnt;
   assign w_tmask_nxt = r_tmask | w_tog;
   assign w_last      = (r_gcnt == r_gate - c_cnt_one);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state      <= S_IDLE;
         r_gate       <= c_gate_rst;
         r_sel        <= 5'd0;
         r_gcnt       <= '0;
         r_ecnt       <= '0;
         r_tmask      <= '0;
         r_meas_cnt   <= '0;
         r_meas_pins  <= '0;
         r_meas_valid <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_meas_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (set_gate_en) begin
                  r_gate <= (set_gate == '0) ? c_cnt_one : set_gate;
                  r_sel  <= (int'(set_sel) >= PIN_W) ? 5'd0 : set_sel;
               end else if (sw_en) begin
                  r_state <= S_GATE;
                  r_busy  <= 1'b1;
                  r_gcnt  <= '0;
                  r_ecnt  <= '0;
                  r_tmask <= '0;
               end
            end
            S_GATE: begin
               if (!sw_en) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_ecnt  <= w_ecnt_nxt;
                  r_tmask <= w_tmask_nxt;
                  // Results take the next-state values so a final-cycle edge counts.
                  if (w_last) begin
                     r_state      <= S_DONE;
                     r_busy       <= 1'b0;
                     r_meas_cnt   <= w_ecnt_nxt;
                     r_meas_pins  <= w_tmask_nxt;
                     r_meas_valid <= 1'b1;
                  end else begin
                     r_gcnt <= r_gcnt + c_cnt_one;
                  end
               end
            end
            S_DONE: begin
               if (sw_en) begin
                  r_state <= S_GATE;
                  r_busy  <= 1'b1;
                  r_gcnt  <= '0;
                  r_ecnt  <= '0;
                  r_tmask <= '0;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign meas_cnt   = r_meas_cnt;
   assign meas_pins  = r_meas_pins;
   assign meas_valid = r_meas_valid;
   assign busy       = r_busy;

endmodule
`default_nettype wire
